// File: rtl/cache_types.sv
// Shared cache-controller types: the controller state, the miss-fill stage
// state and the default geometry of the cache.
package cache_types;

   localparam int CACHE_WAYS            = 4;
   localparam int CACHE_SETS            = 16;
   localparam int CACHE_TAG_SIZE        = 24;
   localparam int CACHE_LINE_SIZE_BITS  = 256;

   localparam int CACHE_WAY_W    = $clog2(CACHE_WAYS);
   localparam int CACHE_SET_W    = $clog2(CACHE_SETS);
   localparam int CACHE_OFFSET_W = $clog2(CACHE_LINE_SIZE_BITS / 8);
   localparam int CACHE_ATAG_W   = CACHE_TAG_SIZE - 1;

   typedef enum logic [2:0] {
      idle_s,
      compare_tag_s,
      write_back_s,
      allocate_s
   } state_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL,
      DONE
   } alloc_state_t;

   typedef logic [CACHE_LINE_SIZE_BITS-1:0] line_t;
   typedef logic [CACHE_TAG_SIZE-1:0]       tag_entry_t;
   typedef logic [CACHE_ATAG_W-1:0]         addr_tag_t;
   typedef logic [CACHE_SET_W-1:0]          set_idx_t;
   typedef logic [CACHE_WAY_W-1:0]          way_idx_t;

endpackage

// File: rtl/allocate.sv
// Cache miss-fill stage: reads the missed line from memory after any
// writeback has finished, then writes it into the arrays in one cycle.
module allocate
   import cache_types::*;
#(
   parameter int WAYS            = CACHE_WAYS,
   parameter int SETS            = CACHE_SETS,
   parameter int TAG_SIZE        = CACHE_TAG_SIZE,
   parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_BITS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  state_t                      state,
   input  logic                        active_alloc,
   input  logic [TAG_SIZE-2:0]         miss_tag,
   input  logic [$clog2(SETS)-1:0]     miss_set,
   input  logic [$clog2(WAYS)-1:0]     victim_way,
   input  logic                        mem_resp,
   input  logic [CACHE_LINE_SIZE-1:0]  mem_rdata,
   output logic                        mem_read,
   output logic [31:0]                 mem_addr,
   output logic                        fill_we,
   output logic [CACHE_LINE_SIZE-1:0]  fill_line,
   output logic [TAG_SIZE-1:0]         fill_tag,
   output logic [$clog2(SETS)-1:0]     fill_set,
   output logic [$clog2(WAYS)-1:0]     fill_way,
   output logic                        alloc_done
);

   localparam int WAY_W  = $clog2(WAYS);
   localparam int SET_W  = $clog2(SETS);
   localparam int OFF_W  = $clog2(CACHE_LINE_SIZE / 8);
   localparam int ATAG_W = TAG_SIZE - 1;

   if (ATAG_W + SET_W + OFF_W != 32) begin : g_addr_width_check
      $error("allocate: tag, set and offset widths must sum to 32 bits");
   end

   alloc_state_t               fsm_q, fsm_d;
   logic [ATAG_W-1:0]          ctx_tag_q, ctx_tag_d;
   logic [SET_W-1:0]           ctx_set_q, ctx_set_d;
   logic [WAY_W-1:0]           ctx_way_q, ctx_way_d;
   logic [ATAG_W-1:0]          snap_tag_q, snap_tag_d;
   logic [SET_W-1:0]           snap_set_q, snap_set_d;
   logic [WAY_W-1:0]           snap_way_q, snap_way_d;
   logic [CACHE_LINE_SIZE-1:0] line_q, line_d;
   logic                       mem_resp_reg_q, mem_resp_reg_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q          <= IDLE;
         ctx_tag_q      <= '0;
         ctx_set_q      <= '0;
         ctx_way_q      <= '0;
         snap_tag_q     <= '0;
         snap_set_q     <= '0;
         snap_way_q     <= '0;
         line_q         <= '0;
         mem_resp_reg_q <= 1'b0;
      end else begin
         fsm_q          <= fsm_d;
         ctx_tag_q      <= ctx_tag_d;
         ctx_set_q      <= ctx_set_d;
         ctx_way_q      <= ctx_way_d;
         snap_tag_q     <= snap_tag_d;
         snap_set_q     <= snap_set_d;
         snap_way_q     <= snap_way_d;
         line_q         <= line_d;
         mem_resp_reg_q <= mem_resp_reg_d;
      end
   end

   always_comb begin
      fsm_d          = fsm_q;
      ctx_tag_d      = ctx_tag_q;
      ctx_set_d      = ctx_set_q;
      ctx_way_d      = ctx_way_q;
      snap_tag_d     = snap_tag_q;
      snap_set_d     = snap_set_q;
      snap_way_d     = snap_way_q;
      line_d         = line_q;
      mem_resp_reg_d = mem_resp;
      mem_read       = 1'b0;
      fill_we        = 1'b0;
      alloc_done     = 1'b0;

      if (state == compare_tag_s) begin
         ctx_tag_d = miss_tag;
         ctx_set_d = miss_set;
         ctx_way_d = victim_way;
      end

      case (fsm_q)
         IDLE: begin
            // A response now or last cycle belongs to the writeback tail.
            if (active_alloc && !mem_resp && !mem_resp_reg_q) begin
               fsm_d      = REQ;
               snap_tag_d = ctx_tag_q;
               snap_set_d = ctx_set_q;
               snap_way_d = ctx_way_q;
            end
         end
         REQ: begin
            mem_read = 1'b1;
            if (mem_resp) begin
               line_d = mem_rdata;
               fsm_d  = FILL;
            end
         end
         FILL: begin
            fill_we = 1'b1;
            fsm_d   = DONE;
         end
         DONE: begin
            alloc_done = 1'b1;
            if (!active_alloc) begin
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   assign mem_addr  = {snap_tag_q, snap_set_q, {OFF_W{1'b0}}};
   assign fill_line = line_q;
   assign fill_tag  = {1'b0, snap_tag_q};
   assign fill_set  = snap_set_q;
   assign fill_way  = snap_way_q;

endmodule
